multicycle_control: RTL

- Main control FSM for the multi-cycle MIPS-subset CPU. It sits directly downstream of the instruction register.
- Consumes the latched opcode/funct fields and the ALU zero flag.
- Drives every write enable and datapath mux select, including the instruction register's ir_we.
- One instruction completes per FSM walk: FETCH, then DECODE, then instruction-specific states, then back to FETCH.

---
 rtl/mc_pkg.sv | 59 +++++
 rtl/mc_decode.sv | 36 +++
 rtl/multicycle_control.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control FSM: states, opcodes, functs,
// ALU operation codes and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_LW_WB     = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BNE_EXEC  = 4'd8,
    S_XORI_EXEC = 4'd9,
    S_I_WB      = 4'd10,
    S_J_EXEC    = 4'd11,
    S_JAL_EXEC  = 4'd12,
    S_JR_EXEC   = 4'd13,
    S_TRAP      = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] DST_R31 = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_REG    = 2'b11;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct dispatch for DECODE plus the R-type ALU control
// decode; an unsupported encoding dispatches to FETCH and flags illegal.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output state_t     dispatch,
  output logic       illegal,
  output logic [2:0] r_alu_op
);

  always_comb begin
    dispatch = S_FETCH;
    illegal  = 1'b0;
    r_alu_op = ALU_ADD;
    case (opcode)
      OP_LW, OP_SW: dispatch = S_MEM_ADDR;
      OP_J:         dispatch = S_J_EXEC;
      OP_JAL:       dispatch = S_JAL_EXEC;
      OP_BNE:       dispatch = S_BNE_EXEC;
      OP_XORI:      dispatch = S_XORI_EXEC;
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin dispatch = S_R_EXEC; r_alu_op = ALU_ADD; end
          FN_SUB: begin dispatch = S_R_EXEC; r_alu_op = ALU_SUB; end
          FN_SLT: begin dispatch = S_R_EXEC; r_alu_op = ALU_SLT; end
          FN_JR:  dispatch = S_JR_EXEC;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS-subset CPU (Moore outputs except
// pc_we in BNE_EXEC). MC_ILLEGAL_TRAP_EN: illegal instructions lock in TRAP.
//
// state      | meaning
// FETCH      | read instruction, PC <= PC+4
// DECODE     | load A/B, ALUOut <= branch target, dispatch
// MEM_ADDR   | ALUOut <= A + sext(imm)
// MEM_RD     | MDR <= mem[ALUOut]
// LW_WB      | rt <= MDR
// MEM_WR     | mem[ALUOut] <= B
// R_EXEC     | ALUOut <= A op B
// R_WB       | rd <= ALUOut
// BNE_EXEC   | compare A,B; PC <= ALUOut if not equal
// XORI_EXEC  | ALUOut <= A ^ zext(imm)
// I_WB       | rt <= ALUOut
// J_EXEC     | PC <= jump target
// JAL_EXEC   | PC <= jump target, r31 <= PC
// JR_EXEC    | PC <= A
// TRAP       | locked after illegal instruction (trap build only)
module multicycle_control
  import mc_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  output logic       ir_we,
  output logic       pc_we,
  output logic       mem_we,
  output logic       iord,
  output logic       ab_we,
  output logic       aluout_we,
  output logic       mdr_we,
  output logic       reg_we,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_sel,
  output logic [2:0] alu_op,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] pc_src,
  output logic [3:0] state_o,
  output logic       illegal
);

  state_t     state, state_nxt;
  state_t     dispatch;
  logic       dec_illegal;
  logic [2:0] r_alu_op;
  logic       ir_we_c, pc_we_c, mem_we_c, ab_we_c, aluout_we_c, mdr_we_c, reg_we_c;

  mc_decode u_decode (
    .opcode   (opcode),
    .funct    (funct),
    .dispatch (dispatch),
    .illegal  (dec_illegal),
    .r_alu_op (r_alu_op)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= state_t'(RESET_STATE);
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE && dec_illegal) illegal <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = S_FETCH;
    ir_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    mem_we_c    = 1'b0;
    ab_we_c     = 1'b0;
    aluout_we_c = 1'b0;
    mdr_we_c    = 1'b0;
    reg_we_c    = 1'b0;
    iord        = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_B;
    ext_sel     = 1'b0;
    alu_op      = ALU_ADD;
    reg_dst     = DST_RT;
    mem_to_reg  = M2R_ALUOUT;
    pc_src      = PCS_ALU;
    case (state)
      S_FETCH: begin
        ir_we_c   = 1'b1;
        pc_we_c   = 1'b1;
        alu_src_b = SRCB_FOUR;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ab_we_c     = 1'b1;
        aluout_we_c = 1'b1;
        alu_src_b   = SRCB_BRANCH;
`ifdef MC_ILLEGAL_TRAP_EN
        state_nxt   = dec_illegal ? S_TRAP : dispatch;
`else
        state_nxt   = dispatch;
`endif
      end
      S_MEM_ADDR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_IMM;
        aluout_we_c = 1'b1;
        state_nxt   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        iord      = 1'b1;
        mdr_we_c  = 1'b1;
        state_nxt = S_LW_WB;
      end
      S_LW_WB: begin
        reg_we_c   = 1'b1;
        mem_to_reg = M2R_MDR;
      end
      S_MEM_WR: begin
        iord     = 1'b1;
        mem_we_c = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a   = 1'b1;
        alu_op      = r_alu_op;
        aluout_we_c = 1'b1;
        state_nxt   = S_R_WB;
      end
      S_R_WB: begin
        reg_we_c = 1'b1;
        reg_dst  = DST_RD;
      end
      S_BNE_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PCS_ALUOUT;
        pc_we_c   = !alu_zero;
      end
      S_XORI_EXEC: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_IMM;
        ext_sel     = 1'b1;
        alu_op      = ALU_XOR;
        aluout_we_c = 1'b1;
        state_nxt   = S_I_WB;
      end
      S_I_WB: reg_we_c = 1'b1;
      S_J_EXEC: begin
        pc_src  = PCS_JUMP;
        pc_we_c = 1'b1;
      end
      // PC already holds PC+4 here, so r31 captures the return address.
      S_JAL_EXEC: begin
        pc_src     = PCS_JUMP;
        pc_we_c    = 1'b1;
        reg_we_c   = 1'b1;
        reg_dst    = DST_R31;
        mem_to_reg = M2R_PC;
      end
      S_JR_EXEC: begin
        pc_src  = PCS_REG;
        pc_we_c = 1'b1;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP: state_nxt = S_TRAP;
`endif
      default: state_nxt = S_FETCH;
    endcase
  end

  // Enables are gated by rst_n so nothing can write after the reset edge.
  assign ir_we     = ir_we_c     & rst_n;
  assign pc_we     = pc_we_c     & rst_n;
  assign mem_we    = mem_we_c    & rst_n;
  assign ab_we     = ab_we_c     & rst_n;
  assign aluout_we = aluout_we_c & rst_n;
  assign mdr_we    = mdr_we_c    & rst_n;
  assign reg_we    = reg_we_c    & rst_n;
  assign state_o   = state;

endmodule
